// File: rtl/wired_lsu_bus_ctrl.sv
// LSU-to-memory bus controller: line refills, uncached reads and uncached writes,
// one transaction in flight. Every output comes straight from a register.
module wired_lsu_bus_ctrl #(
  parameter int LINE_WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      lsu_req_valid_i,
  output logic                      lsu_req_ready_o,
  input  logic [1:0]                lsu_req_op_i,
  input  logic [31:0]               lsu_req_addr_i,
  input  logic [31:0]               lsu_req_wdata_i,
  input  logic [3:0]                lsu_req_wstrb_i,
  output logic                      lsu_resp_valid_o,
  input  logic                      lsu_resp_ready_i,
  output logic [32*LINE_WORDS-1:0]  lsu_resp_data_o,
  output logic                      lsu_resp_err_o,
  output logic                      mem_req_valid_o,
  input  logic                      mem_req_ready_i,
  output logic                      mem_req_write_o,
  output logic [31:0]               mem_req_addr_o,
  output logic [1:0]                mem_req_len_o,
  output logic [31:0]               mem_req_wdata_o,
  output logic [3:0]                mem_req_wstrb_o,
  input  logic                      mem_rvalid_i,
  input  logic [31:0]               mem_rdata_i,
  input  logic                      mem_rlast_i,
  input  logic                      mem_rerr_i,
  input  logic                      mem_bvalid_i,
  input  logic                      mem_berr_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MREQ = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [1:0] OP_REFILL  = 2'b00;
  localparam logic [1:0] OP_UC_WR   = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;
  localparam logic [1:0] REFILL_LEN = 2'(LINE_WORDS - 1);

  state_t                     r_state;
  logic                       r_req_ready;
  logic                       r_mem_valid;
  logic                       r_mem_write;
  logic [31:0]                r_mem_addr;
  logic [1:0]                 r_mem_len;
  logic [31:0]                r_mem_wdata;
  logic [3:0]                 r_mem_wstrb;
  logic                       r_resp_valid;
  logic                       r_resp_err;
  logic [32*LINE_WORDS-1:0]   r_resp_data;
  logic [1:0]                 r_cnt;

  // Refills are line aligned, uncached accesses word aligned.
  logic [31:0] w_addr_mask;
  assign w_addr_mask = (lsu_req_op_i == OP_REFILL) ? 32'hFFFF_FFF0 : 32'hFFFF_FFFC;

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b0;
      r_mem_valid  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= 32'h0;
      r_mem_len    <= 2'b00;
      r_mem_wdata  <= 32'h0;
      r_mem_wstrb  <= 4'h0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_data  <= '0;
      r_cnt        <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_req_ready && lsu_req_valid_i) begin
            r_req_ready <= 1'b0;
            r_resp_data <= '0;
            r_cnt       <= 2'b00;
            if (lsu_req_op_i == OP_ILLEGAL) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
            end else begin
              r_state     <= S_MREQ;
              r_mem_valid <= 1'b1;
              r_mem_write <= (lsu_req_op_i == OP_UC_WR);
              r_mem_addr  <= lsu_req_addr_i & w_addr_mask;
              r_mem_len   <= (lsu_req_op_i == OP_REFILL) ? REFILL_LEN : 2'b00;
              r_mem_wdata <= lsu_req_wdata_i;
              r_mem_wstrb <= lsu_req_wstrb_i;
              r_resp_err  <= 1'b0;
            end
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        S_MREQ: begin
          if (mem_req_ready_i) begin
            r_mem_valid <= 1'b0;
            r_state     <= S_DATA;
          end
        end
        S_DATA: begin
          if (r_mem_write) begin
            if (mem_bvalid_i) begin
              r_resp_err   <= mem_berr_i;
              r_resp_valid <= 1'b1;
              r_state      <= S_RESP;
            end
          end else if (mem_rvalid_i) begin
            r_resp_data[{r_cnt, 5'd0} +: 32] <= mem_rdata_i;
            // An early rlast means a short burst; it ends the read but flags an error.
            if (mem_rlast_i || (r_cnt == r_mem_len)) begin
              r_resp_err   <= r_resp_err | mem_rerr_i | (r_cnt != r_mem_len);
              r_resp_valid <= 1'b1;
              r_state      <= S_RESP;
            end else begin
              r_resp_err <= r_resp_err | mem_rerr_i;
              r_cnt      <= r_cnt + 2'd1;
            end
          end
        end
        S_RESP: begin
          if (lsu_resp_ready_i) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_req_ready  <= 1'b0;
          r_mem_valid  <= 1'b0;
          r_resp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign lsu_req_ready_o  = r_req_ready;
  assign lsu_resp_valid_o = r_resp_valid;
  assign lsu_resp_data_o  = r_resp_data;
  assign lsu_resp_err_o   = r_resp_err;
  assign mem_req_valid_o  = r_mem_valid;
  assign mem_req_write_o  = r_mem_write;
  assign mem_req_addr_o   = r_mem_addr;
  assign mem_req_len_o    = r_mem_len;
  assign mem_req_wdata_o  = r_mem_wdata;
  assign mem_req_wstrb_o  = r_mem_wstrb;

endmodule
